power_meter_ctrl: RTL and testbench

Parametrised successor to the bowling power-level FSM. It contains its own step-tick divider on CLOCK_50 and sweeps a power level from 1 to LEVELS while the charge button is held, in wrap or bounce mode. On release it latches the level and offers it to the throw logic through a valid/ack handshake. It also drives a thermometer LED bar. It sits between the button debouncer and the ball-launch/physics block.

---
 rtl/power_meter_ctrl.sv | 126 ++++++++++++
 tb/tb_power_meter_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/power_meter_ctrl.sv
// Charge-button power meter: sweeps a level 1..LEVELS while the button is held,
// then latches the released level and offers it to the throw logic via valid/ack.
module power_meter_ctrl #(
  parameter int unsigned LEVELS      = 4,
  parameter int unsigned LVL_W       = 3,
  parameter int unsigned TICK_CYCLES = 25000000,
  parameter int unsigned BOUNCE      = 0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic              ack,
  output logic [LVL_W-1:0]  pow_lvl,
  output logic [LEVELS-1:0] leds,
  output logic              charging,
  output logic [LVL_W-1:0]  locked_lvl,
  output logic              locked_valid
);

  localparam int unsigned      CNT_W     = $clog2(TICK_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(LEVELS);

  typedef enum logic [1:0] {IDLE, CHARGE, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             dir_down;
  logic             enable_d;
  logic [LVL_W-1:0] next_lvl;
  logic             next_down;

  function automatic logic [LEVELS-1:0] therm(input logic [LVL_W-1:0] lvl);
    logic [LEVELS-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < LEVELS; i++) begin
      t[i] = (32'(lvl) > i);
    end
    return t;
  endfunction

  // Level after one step; a single-level meter never moves.
  always_comb begin
    next_lvl  = pow_lvl;
    next_down = dir_down;
    if (LEVELS > 1) begin
      if (BOUNCE == 0) begin
        next_lvl = (pow_lvl == LVL_MAX) ? LVL_ONE : pow_lvl + LVL_ONE;
      end else if (!dir_down) begin
        if (pow_lvl == LVL_MAX) begin
          next_lvl  = pow_lvl - LVL_ONE;
          next_down = 1'b1;
        end else begin
          next_lvl = pow_lvl + LVL_ONE;
        end
      end else begin
        if (pow_lvl == LVL_ONE) begin
          next_lvl  = pow_lvl + LVL_ONE;
          next_down = 1'b0;
        end else begin
          next_lvl = pow_lvl - LVL_ONE;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      pow_lvl      <= LVL_ONE;
      dir_down     <= 1'b0;
      tick_cnt     <= '0;
      locked_lvl   <= '0;
      locked_valid <= 1'b0;
      charging     <= 1'b0;
      enable_d     <= 1'b1;
    end else begin
      enable_d <= enable;
      case (state)
        IDLE: begin
          pow_lvl <= LVL_ONE;
          if (enable && !enable_d) begin
            state    <= CHARGE;
            tick_cnt <= '0;
            charging <= 1'b1;
            dir_down <= 1'b0;
          end
        end
        CHARGE: begin
          // Release takes precedence over a coincident tick.
          if (!enable) begin
            state        <= HOLD;
            locked_lvl   <= pow_lvl;
            locked_valid <= 1'b1;
            charging     <= 1'b0;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            pow_lvl  <= next_lvl;
            dir_down <= next_down;
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (ack) begin
            state        <= IDLE;
            locked_valid <= 1'b0;
            pow_lvl      <= LVL_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    case (state)
      CHARGE:  leds = therm(pow_lvl);
      HOLD:    leds = therm(locked_lvl);
      default: leds = '0;
    endcase
  end

endmodule

// File: tb/tb_power_meter_ctrl.sv
// Directed bench for power_meter_ctrl: wrap, bounce and single-level instances.
module tb_power_meter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic en_a = 1'b0, ack_a = 1'b0;
  logic en_b = 1'b0, ack_b = 1'b0;
  logic en_c = 1'b0, ack_c = 1'b0;

  logic [2:0] pow_a, locked_a, pow_b, locked_b, pow_c, locked_c;
  logic [3:0] leds_a, leds_b;
  logic [0:0] leds_c;
  logic       chg_a, val_a, chg_b, val_b, chg_c, val_c;

  int tests = 0;
  int fails = 0;

  power_meter_ctrl #(.LEVELS(4), .LVL_W(3), .TICK_CYCLES(4), .BOUNCE(0)) u_wrap (
    .CLOCK_50(clk), .reset(reset), .enable(en_a), .ack(ack_a), .pow_lvl(pow_a),
    .leds(leds_a), .charging(chg_a), .locked_lvl(locked_a), .locked_valid(val_a));

  power_meter_ctrl #(.LEVELS(4), .LVL_W(3), .TICK_CYCLES(4), .BOUNCE(1)) u_bounce (
    .CLOCK_50(clk), .reset(reset), .enable(en_b), .ack(ack_b), .pow_lvl(pow_b),
    .leds(leds_b), .charging(chg_b), .locked_lvl(locked_b), .locked_valid(val_b));

  power_meter_ctrl #(.LEVELS(1), .LVL_W(3), .TICK_CYCLES(1), .BOUNCE(0)) u_one (
    .CLOCK_50(clk), .reset(reset), .enable(en_c), .ack(ack_c), .pow_lvl(pow_c),
    .leds(leds_c), .charging(chg_c), .locked_lvl(locked_c), .locked_valid(val_c));

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    cyc(2);
    tests++;
    if ({pow_a, leds_a, chg_a, val_a, locked_a} !== {3'd1, 4'b0000, 1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_state got pow=%0d leds=%b chg=%b val=%b lock=%0d want 1 0000 0 0 0",
               pow_a, leds_a, chg_a, val_a, locked_a);
    end
    reset = 1'b0;
    cyc(4);
    tests++;
    if ({chg_a, chg_b, chg_c} !== 3'b000) begin
      fails++;
      $display("FAIL held_through_reset got chg=%b%b%b want 000", chg_a, chg_b, chg_c);
    end
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    cyc(1);
  endtask

  task automatic test_wrap;
    int e;
    en_a = 1'b1;
    cyc(1);
    tests++;
    if (chg_a !== 1'b1) begin
      fails++;
      $display("FAIL wrap_start got chg=%b want 1", chg_a);
    end
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      if (k % 4 == 0) begin
        e = ((k / 4) % 4) + 1;
        tests++;
        if ({pow_a, leds_a} !== {3'(e), 4'((1 << e) - 1)}) begin
          fails++;
          $display("FAIL wrap_step k=%0d got pow=%0d leds=%b want %0d %b",
                   k, pow_a, leds_a, e, 4'((1 << e) - 1));
        end
      end
    end
    en_a = 1'b0;
    cyc(1);
    tests++;
    if ({locked_a, val_a, chg_a, leds_a, pow_a} !== {3'd3, 1'b1, 1'b0, 4'b0111, 3'd3}) begin
      fails++;
      $display("FAIL release got lock=%0d val=%b chg=%b leds=%b pow=%0d want 3 1 0 0111 3",
               locked_a, val_a, chg_a, leds_a, pow_a);
    end
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      tests++;
      if ({locked_a, val_a, chg_a, leds_a, pow_a} !== {3'd3, 1'b1, 1'b0, 4'b0111, 3'd3}) begin
        fails++;
        $display("FAIL hold_stable c=%0d got lock=%0d val=%b chg=%b leds=%b pow=%0d want 3 1 0 0111 3",
                 k, locked_a, val_a, chg_a, leds_a, pow_a);
      end
    end
    ack_a = 1'b1;
    cyc(1);
    ack_a = 1'b0;
    tests++;
    if ({val_a, pow_a, leds_a, chg_a, locked_a} !== {1'b0, 3'd1, 4'b0000, 1'b0, 3'd3}) begin
      fails++;
      $display("FAIL ack got val=%b pow=%0d leds=%b chg=%b lock=%0d want 0 1 0000 0 3",
               val_a, pow_a, leds_a, chg_a, locked_a);
    end
  endtask

  task automatic test_tiebreak;
    en_a = 1'b1;
    cyc(8);
    en_a = 1'b0; ack_a = 1'b1;
    cyc(1);
    ack_a = 1'b0;
    tests++;
    if ({locked_a, val_a, pow_a} !== {3'd2, 1'b1, 3'd2}) begin
      fails++;
      $display("FAIL tie_release got lock=%0d val=%b pow=%0d want 2 1 2", locked_a, val_a, pow_a);
    end
    en_a = 1'b1;
    cyc(3);
    tests++;
    if ({val_a, chg_a, locked_a} !== {1'b1, 1'b0, 3'd2}) begin
      fails++;
      $display("FAIL hold_ignores_enable got val=%b chg=%b lock=%0d want 1 0 2", val_a, chg_a, locked_a);
    end
    ack_a = 1'b1;
    cyc(1);
    ack_a = 1'b0;
    tests++;
    if (val_a !== 1'b0) begin
      fails++;
      $display("FAIL tie_ack got val=%b want 0", val_a);
    end
    cyc(3);
    tests++;
    if (chg_a !== 1'b0) begin
      fails++;
      $display("FAIL held_after_ack got chg=%b want 0", chg_a);
    end
    en_a = 1'b0;
    cyc(1);
    en_a = 1'b1;
    cyc(1);
    tests++;
    if (chg_a !== 1'b1) begin
      fails++;
      $display("FAIL repress got chg=%b want 1", chg_a);
    end
  endtask

  task automatic test_reset_mid;
    cyc(8);
    tests++;
    if (pow_a !== 3'd3) begin
      fails++;
      $display("FAIL mid_charge_level got pow=%0d want 3", pow_a);
    end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    tests++;
    if ({chg_a, pow_a, val_a, leds_a} !== {1'b0, 3'd1, 1'b0, 4'b0000}) begin
      fails++;
      $display("FAIL reset_in_charge got chg=%b pow=%0d val=%b leds=%b want 0 1 0 0000",
               chg_a, pow_a, val_a, leds_a);
    end
    cyc(2);
    tests++;
    if (chg_a !== 1'b0) begin
      fails++;
      $display("FAIL held_after_mid_reset got chg=%b want 0", chg_a);
    end
    en_a = 1'b0;
    cyc(1);
    en_a = 1'b1;
    cyc(3);
    en_a = 1'b0;
    cyc(1);
    tests++;
    if ({val_a, locked_a} !== {1'b1, 3'd1}) begin
      fails++;
      $display("FAIL short_press got val=%b lock=%0d want 1 1", val_a, locked_a);
    end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    tests++;
    if ({val_a, locked_a, chg_a, leds_a} !== {1'b0, 3'd0, 1'b0, 4'b0000}) begin
      fails++;
      $display("FAIL reset_in_hold got val=%b lock=%0d chg=%b leds=%b want 0 0 0 0000",
               val_a, locked_a, chg_a, leds_a);
    end
  endtask

  task automatic test_bounce;
    int seq [8] = '{1, 2, 3, 4, 3, 2, 1, 2};
    int e;
    cyc(1);
    en_b = 1'b1;
    cyc(1);
    tests++;
    if ({chg_b, pow_b} !== {1'b1, 3'd1}) begin
      fails++;
      $display("FAIL bounce_start got chg=%b pow=%0d want 1 1", chg_b, pow_b);
    end
    for (int k = 1; k <= 28; k++) begin
      cyc(1);
      if (k % 4 == 0) begin
        e = seq[k / 4];
        tests++;
        if ({pow_b, leds_b} !== {3'(e), 4'((1 << e) - 1)}) begin
          fails++;
          $display("FAIL bounce_step k=%0d got pow=%0d leds=%b want %0d %b",
                   k, pow_b, leds_b, e, 4'((1 << e) - 1));
        end
      end
    end
    en_b = 1'b0;
    cyc(1);
  endtask

  task automatic test_levels1;
    en_c = 1'b1;
    cyc(1);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if ({pow_c, leds_c, chg_c} !== {3'd1, 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL one_level c=%0d got pow=%0d leds=%b chg=%b want 1 1 1", k, pow_c, leds_c, chg_c);
      end
      cyc(1);
    end
    en_c = 1'b0;
    cyc(1);
    tests++;
    if ({locked_c, val_c, pow_c} !== {3'd1, 1'b1, 3'd1}) begin
      fails++;
      $display("FAIL one_level_lock got lock=%0d val=%b pow=%0d want 1 1 1", locked_c, val_c, pow_c);
    end
  endtask

  initial begin
    test_reset;
    test_wrap;
    test_tiebreak;
    test_reset_mid;
    test_bounce;
    test_levels1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
